raster_scan_engine: RTL and testbench

//  Parametrised next-generation triangle rasterizer. Accepts one triangle per valid/ready handshake,

---
 rtl/raster_scan_engine_if.sv | 47 ++++
 rtl/raster_scan_engine.sv | 216 +++++++++++++++++++++
 tb/tb_raster_scan_engine.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_scan_engine_if.sv
// ---------------------------------------------------------------------------
// raster_scan_engine_if
// Groups the triangle-in and pixel-out handshakes of the rasterizer.
//   slave  : engine side (receives triangles, produces pixels)
//   master : environment side (vertex front-end + framebuffer writer)
// Signals:
//   TRI_VALID / TRI_READY / TRI_IN : one triangle {v0x,v0y,v1x,v1y,v2x,v2y,color}
//   PIX_VALID / PIX_READY          : pixel stream handshake
//   PIX_X, PIX_Y, PIX_COLOR        : pixel position and flat colour
//   PIX_INSIDE                     : sample centre lies inside the triangle
//   DONE, BUSY                     : triangle finished pulse / engine not idle
//   DBG_STATE                      : current FSM state for observation
// Handshake rule (both directions): a transfer happens on a rising CLK edge
// where VALID and READY are both high; once VALID is raised, it and its
// payload stay stable until that transfer.
// ---------------------------------------------------------------------------
interface raster_scan_engine_if #(
    parameter int W  = 16,
    parameter int CW = 16,
    parameter int XW = 9,
    parameter int YW = 8
);
    logic              TRI_VALID;
    logic              TRI_READY;
    logic [6*W+CW-1:0] TRI_IN;
    logic              PIX_VALID;
    logic              PIX_READY;
    logic [XW-1:0]     PIX_X;
    logic [YW-1:0]     PIX_Y;
    logic [CW-1:0]     PIX_COLOR;
    logic              PIX_INSIDE;
    logic              DONE;
    logic              BUSY;
    logic [2:0]        DBG_STATE;

    modport slave (
        input  TRI_VALID, TRI_IN, PIX_READY,
        output TRI_READY, PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, PIX_INSIDE,
               DONE, BUSY, DBG_STATE
    );

    modport master (
        output TRI_VALID, TRI_IN, PIX_READY,
        input  TRI_READY, PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, PIX_INSIDE,
               DONE, BUSY, DBG_STATE
    );
endinterface

// File: rtl/raster_scan_engine.sv
// ---------------------------------------------------------------------------
// raster_scan_engine
// Triangle rasterizer: accepts one triangle per handshake, computes a
// screen-clipped bounding box and walks it row-major using incremental edge
// functions, emitting a backpressured pixel stream.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous, active-high reset
//   bus  : raster_scan_engine_if.slave (triangle in, pixel out, DONE/BUSY,
//          DBG_STATE)
// Optional feature macro: RASTER_WINDING_AUTO_EN
//   defined   : clockwise (area<0) triangles are rasterised by negating edge
//               values and steps; only zero-area triangles are culled.
//   undefined : area<=0 triangles are culled (no pixels, DONE still pulses).
// ---------------------------------------------------------------------------
module raster_scan_engine #(
    parameter int W        = 16,
    parameter int FRAC     = 6,
    parameter int CW       = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int EMIT_ALL = 0
) (
    input  logic                CLK,
    input  logic                RST,
    raster_scan_engine_if.slave bus
);
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int EW = 2*W+2;
    localparam logic signed [W-1:0]  XLIM = W'(SCREEN_W-1);
    localparam logic signed [W-1:0]  YLIM = W'(SCREEN_H-1);
    localparam logic signed [EW-1:0] HALF = EW'(1 << (FRAC-1));

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EDGE, S_SCAN, S_ROW, S_FIN} state_t;

    function automatic logic signed [EW-1:0] sx(input logic signed [W-1:0] v);
        return {{(EW-W){v[W-1]}}, v};
    endfunction

    // E_ab(p) = (px-ax)*(by-ay) - (py-ay)*(bx-ax)
    function automatic logic signed [EW-1:0] edge_fn(
        input logic signed [EW-1:0] ax, ay, bx, by, px, py);
        return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
    endfunction

    function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a, b, c);
        logic signed [W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a, b, c);
        logic signed [W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    state_t r_state, w_next;

    logic signed [W-1:0]  r_vx [3];
    logic signed [W-1:0]  r_vy [3];
    logic [CW-1:0]        r_color;
    logic [XW-1:0]        r_xmin, r_xmax, r_x;
    logic [YW-1:0]        r_ymin, r_ymax, r_y;
    logic signed [EW-1:0] r_e  [3];   // edge values at current pixel
    logic signed [EW-1:0] r_rs [3];   // edge values at start of current row
    logic signed [EW-1:0] r_a  [3];   // per-x step
    logic signed [EW-1:0] r_b  [3];   // per-y step

    logic signed [W-1:0]  w_minx, w_maxx, w_miny, w_maxy;
    logic signed [W-1:0]  w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [EW-1:0] w_area, w_spx, w_spy;
    logic signed [EW-1:0] w_e0 [3];
    logic signed [EW-1:0] w_a0 [3];
    logic signed [EW-1:0] w_b0 [3];
    logic                 w_empty, w_cull, w_inside, w_pix_valid, w_adv;
    logic                 w_last_x, w_last_y;

    // Bounding box: floor of min/max (arithmetic shift), clipped to the screen.
    assign w_minx = min3(r_vx[0], r_vx[1], r_vx[2]) >>> FRAC;
    assign w_maxx = max3(r_vx[0], r_vx[1], r_vx[2]) >>> FRAC;
    assign w_miny = min3(r_vy[0], r_vy[1], r_vy[2]) >>> FRAC;
    assign w_maxy = max3(r_vy[0], r_vy[1], r_vy[2]) >>> FRAC;
    assign w_xmin = w_minx[W-1] ? '0 : w_minx;
    assign w_ymin = w_miny[W-1] ? '0 : w_miny;
    assign w_xmax = (w_maxx > XLIM) ? XLIM : w_maxx;
    assign w_ymax = (w_maxy > YLIM) ? YLIM : w_maxy;
    assign w_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);

    // Twice the signed area: E01 evaluated at v2; positive for the accepted winding.
    assign w_area = edge_fn(sx(r_vx[0]), sx(r_vy[0]), sx(r_vx[1]), sx(r_vy[1]),
                            sx(r_vx[2]), sx(r_vy[2]));

`ifdef RASTER_WINDING_AUTO_EN
    logic r_neg;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    r_neg <= 1'b0;
        else if (r_state == S_SETUP) r_neg <= w_area[EW-1];
    end
    assign w_cull = (w_area == '0);
`else
    assign w_cull = w_area[EW-1] || (w_area == '0);
`endif

    // Initial edge values at the sample centre of (xmin,ymin), plus steps.
    always_comb begin
        w_spx = ({{(EW-XW){1'b0}}, r_xmin} <<< FRAC) + HALF;
        w_spy = ({{(EW-YW){1'b0}}, r_ymin} <<< FRAC) + HALF;
        for (int i = 0; i < 3; i++) begin
            w_e0[i] = edge_fn(sx(r_vx[i]), sx(r_vy[i]), sx(r_vx[(i+1)%3]),
                              sx(r_vy[(i+1)%3]), w_spx, w_spy);
            w_a0[i] = (sx(r_vy[(i+1)%3]) - sx(r_vy[i])) <<< FRAC;
            w_b0[i] = (sx(r_vx[i]) - sx(r_vx[(i+1)%3])) <<< FRAC;
`ifdef RASTER_WINDING_AUTO_EN
            if (r_neg) begin
                w_e0[i] = -w_e0[i];
                w_a0[i] = -w_a0[i];
                w_b0[i] = -w_b0[i];
            end
`endif
        end
    end

    // Ties (edge == 0) count as inside.
    assign w_inside    = !r_e[0][EW-1] && !r_e[1][EW-1] && !r_e[2][EW-1];
    assign w_pix_valid = (r_state == S_SCAN) && ((EMIT_ALL != 0) || w_inside);
    // Advance on a handshake, or immediately on a skipped (non-emitted) candidate.
    assign w_adv       = !w_pix_valid || bus.PIX_READY;
    assign w_last_x    = (r_x == r_xmax);
    assign w_last_y    = (r_y == r_ymax);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.TRI_VALID) w_next = S_SETUP;
            S_SETUP: w_next = (w_empty || w_cull) ? S_FIN : S_EDGE;
            S_EDGE:  w_next = S_SCAN;
            S_SCAN:  if (w_adv && w_last_x) w_next = w_last_y ? S_FIN : S_ROW;
            S_ROW:   w_next = S_SCAN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_color <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_x     <= '0;
            r_ymin  <= '0;
            r_ymax  <= '0;
            r_y     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
                r_e[i]  <= '0;
                r_rs[i] <= '0;
                r_a[i]  <= '0;
                r_b[i]  <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (bus.TRI_VALID) begin
                    for (int i = 0; i < 3; i++) begin
                        r_vx[i] <= bus.TRI_IN[CW + (5-2*i)*W +: W];
                        r_vy[i] <= bus.TRI_IN[CW + (4-2*i)*W +: W];
                    end
                    r_color <= bus.TRI_IN[CW-1:0];
                end
                S_SETUP: begin
                    r_xmin <= w_xmin[XW-1:0];
                    r_xmax <= w_xmax[XW-1:0];
                    r_ymin <= w_ymin[YW-1:0];
                    r_ymax <= w_ymax[YW-1:0];
                end
                S_EDGE: begin
                    r_x <= r_xmin;
                    r_y <= r_ymin;
                    for (int i = 0; i < 3; i++) begin
                        r_e[i]  <= w_e0[i];
                        r_rs[i] <= w_e0[i];
                        r_a[i]  <= w_a0[i];
                        r_b[i]  <= w_b0[i];
                    end
                end
                S_SCAN: if (w_adv && !w_last_x) begin
                    r_x <= r_x + XW'(1);
                    for (int i = 0; i < 3; i++) r_e[i] <= r_e[i] + r_a[i];
                end
                S_ROW: begin
                    r_x <= r_xmin;
                    r_y <= r_y + YW'(1);
                    for (int i = 0; i < 3; i++) begin
                        r_e[i]  <= r_rs[i] + r_b[i];
                        r_rs[i] <= r_rs[i] + r_b[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.TRI_READY  = (r_state == S_IDLE);
    assign bus.BUSY       = (r_state != S_IDLE);
    assign bus.DONE       = (r_state == S_FIN);
    assign bus.PIX_VALID  = w_pix_valid;
    assign bus.PIX_INSIDE = (r_state == S_SCAN) && w_inside;
    assign bus.PIX_X      = r_x;
    assign bus.PIX_Y      = r_y;
    assign bus.PIX_COLOR  = r_color;
    assign bus.DBG_STATE  = r_state;
endmodule

// File: tb/tb_raster_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_raster_scan_engine
// Directed bench for raster_scan_engine. Two engines share CLK/RST:
// u_dut0 emits inside pixels only, u_dut1 emits every bounding-box pixel.
// Pixel handshakes and DONE pulses are recorded on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_raster_scan_engine;
    localparam int W  = 16;
    localparam int FRAC = 6;
    localparam int CW = 16;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int TW = 6*W+CW;
    localparam int PW = CW+XW+YW+1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    raster_scan_engine_if #(.W(W), .CW(CW), .XW(XW), .YW(YW)) bus0 ();
    raster_scan_engine_if #(.W(W), .CW(CW), .XW(XW), .YW(YW)) bus1 ();

    raster_scan_engine #(.W(W), .FRAC(FRAC), .CW(CW), .SCREEN_W(320), .SCREEN_H(240),
        .EMIT_ALL(0)) u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    raster_scan_engine #(.W(W), .FRAC(FRAC), .CW(CW), .SCREEN_W(320), .SCREEN_H(240),
        .EMIT_ALL(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done0    = 0;
    int done1    = 0;
    int hs1_cyc  = 0;
    int done1_cyc = 0;
    logic [PW-1:0] got0_q[$];
    logic [PW-1:0] got1_q[$];
    logic [PW-1:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus0.PIX_VALID && bus0.PIX_READY)
            got0_q.push_back({bus0.PIX_COLOR, bus0.PIX_X, bus0.PIX_Y, bus0.PIX_INSIDE});
        if (bus0.DONE) done0++;
        if (bus1.PIX_VALID && bus1.PIX_READY) begin
            got1_q.push_back({bus1.PIX_COLOR, bus1.PIX_X, bus1.PIX_Y, bus1.PIX_INSIDE});
            hs1_cyc = cyc;
        end
        if (bus1.DONE) begin
            done1++;
            done1_cyc = cyc;
        end
    end

    function automatic logic [TW-1:0] mk_tri(input logic [W-1:0] ax, ay, bx, by, cx, cy,
                                             input logic [CW-1:0] col);
        return {ax, ay, bx, by, cx, cy, col};
    endfunction

    // Reference pixel list for the right triangle with legs of 4 pixels:
    // sample centre inside iff x + y <= 3, scanned over the 5x5 bounding box.
    task automatic build_exp(input bit emit_all, input logic [CW-1:0] col);
        exp_q.delete();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (emit_all || (x + y <= 3))
                    exp_q.push_back({col, XW'(x), YW'(y), (x + y <= 3) ? 1'b1 : 1'b0});
    endtask

    task automatic send_tri(input int sel, input logic [TW-1:0] t);
        int n;
        n = 0;
        if (sel == 0) begin bus0.TRI_IN = t; bus0.TRI_VALID = 1'b1; end
        else          begin bus1.TRI_IN = t; bus1.TRI_VALID = 1'b1; end
        while (((sel == 0) ? bus0.TRI_READY : bus1.TRI_READY) !== 1'b1 && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        n_checks++;
        if (n >= 50) $display("FAIL send_tri: TRI_READY low for %0d cycles, required < 50", n);
        else n_pass++;
        @(posedge CLK); #1;
        bus0.TRI_VALID = 1'b0;
        bus1.TRI_VALID = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int d, input int budget, output int n);
        n = 0;
        while (((sel == 0) ? done0 : done1) == d && n < budget) begin
            @(posedge CLK); #2; n++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (bus0.TRI_READY !== 1'b1) $display("FAIL reset_tri_ready: got %b, required 1", bus0.TRI_READY); else n_pass++;
        n_checks++; if (bus0.PIX_VALID !== 1'b0) $display("FAIL reset_pix_valid: got %b, required 0", bus0.PIX_VALID); else n_pass++;
        n_checks++; if (bus0.DONE !== 1'b0) $display("FAIL reset_done: got %b, required 0", bus0.DONE); else n_pass++;
        n_checks++; if (bus0.BUSY !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus0.BUSY); else n_pass++;
        n_checks++; if (bus0.PIX_X !== '0) $display("FAIL reset_pix_x: got %0d, required 0", bus0.PIX_X); else n_pass++;
        n_checks++; if (bus0.PIX_Y !== '0) $display("FAIL reset_pix_y: got %0d, required 0", bus0.PIX_Y); else n_pass++;
        n_checks++; if (bus0.PIX_COLOR !== '0) $display("FAIL reset_color: got %h, required 0", bus0.PIX_COLOR); else n_pass++;
        n_checks++; if (bus0.PIX_INSIDE !== 1'b0) $display("FAIL reset_inside: got %b, required 0", bus0.PIX_INSIDE); else n_pass++;
        n_checks++; if (bus1.TRI_READY !== 1'b1) $display("FAIL reset_tri_ready1: got %b, required 1", bus1.TRI_READY); else n_pass++;
    endtask

    task automatic test_inside_only();
        int d, n;
        got0_q.delete();
        build_exp(1'b0, 16'h1234);
        d = done0;
        send_tri(0, mk_tri(0, 0, 0, 256, 256, 0, 16'h1234));
        wait_done(0, d, 100, n);
        n_checks++; if (n >= 100) $display("FAIL inside_done_timeout: waited %0d cycles, required < 100", n); else n_pass++;
        @(posedge CLK); #2;
        n_checks++; if (got0_q.size() !== exp_q.size()) $display("FAIL inside_count: got %0d, required %0d", got0_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got0_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got0_q[i] !== exp_q[i]) $display("FAIL inside_pix[%0d]: got %h, required %h", i, got0_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (done0 - d !== 1) $display("FAIL inside_done_pulses: got %0d, required 1", done0 - d); else n_pass++;
        n_checks++; if ({bus0.TRI_READY, bus0.BUSY} !== 2'b10) $display("FAIL inside_idle: got ready/busy %b, required 10", {bus0.TRI_READY, bus0.BUSY}); else n_pass++;
    endtask

    task automatic test_emit_all();
        int d, n, ins;
        got1_q.delete();
        build_exp(1'b1, 16'hBEEF);
        d = done1;
        send_tri(1, mk_tri(0, 0, 0, 256, 256, 0, 16'hBEEF));
        wait_done(1, d, 100, n);
        n_checks++; if (n >= 100) $display("FAIL emit_all_done_timeout: waited %0d cycles, required < 100", n); else n_pass++;
        @(posedge CLK); #2;
        n_checks++; if (got1_q.size() !== 25) $display("FAIL emit_all_count: got %0d, required 25", got1_q.size()); else n_pass++;
        ins = 0;
        for (int i = 0; i < got1_q.size(); i++) if (got1_q[i][0]) ins++;
        n_checks++; if (ins !== 10) $display("FAIL emit_all_inside_count: got %0d, required 10", ins); else n_pass++;
        for (int i = 0; i < got1_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got1_q[i] !== exp_q[i]) $display("FAIL emit_all_pix[%0d]: got %h, required %h", i, got1_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (done1_cyc !== hs1_cyc + 1) $display("FAIL emit_all_done_timing: done at cycle %0d, required %0d", done1_cyc, hs1_cyc + 1); else n_pass++;
        n_checks++; if (done1 - d !== 1) $display("FAIL emit_all_done_pulses: got %0d, required 1", done1 - d); else n_pass++;
    endtask

    task automatic test_winding();
        int d, n;
        got0_q.delete();
`ifdef RASTER_WINDING_AUTO_EN
        build_exp(1'b0, 16'h0F0F);
`else
        exp_q.delete();
`endif
        d = done0;
        send_tri(0, mk_tri(0, 0, 256, 0, 0, 256, 16'h0F0F));
        wait_done(0, d, 100, n);
        n_checks++; if (n >= 100) $display("FAIL winding_done_timeout: waited %0d cycles, required < 100", n); else n_pass++;
        @(posedge CLK); #2;
        n_checks++; if (got0_q.size() !== exp_q.size()) $display("FAIL winding_count: got %0d, required %0d", got0_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got0_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got0_q[i] !== exp_q[i]) $display("FAIL winding_pix[%0d]: got %h, required %h", i, got0_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (done0 - d !== 1) $display("FAIL winding_done_pulses: got %0d, required 1", done0 - d); else n_pass++;
    endtask

    task automatic test_stall();
        int d, n;
        bit stalled;
        logic [CW+XW+YW-1:0] hold;
        got0_q.delete();
        build_exp(1'b0, 16'h5A5A);
        d = done0;
        stalled = 1'b0;
        hold = '0;
        n = 0;
        send_tri(0, mk_tri(0, 0, 0, 256, 256, 0, 16'h5A5A));
        while (done0 == d && n < 150) begin
            @(posedge CLK); #1; n++;
            if (!stalled && bus0.PIX_VALID && got0_q.size() == 2) begin
                stalled = 1'b1;
                hold = {bus0.PIX_COLOR, bus0.PIX_X, bus0.PIX_Y};
                bus0.PIX_READY = 1'b0;
                repeat (5) begin
                    @(posedge CLK); #1;
                    n_checks++;
                    if ({bus0.PIX_VALID, bus0.PIX_COLOR, bus0.PIX_X, bus0.PIX_Y} !== {1'b1, hold})
                        $display("FAIL stall_hold: got %h, required %h",
                                 {bus0.PIX_VALID, bus0.PIX_COLOR, bus0.PIX_X, bus0.PIX_Y}, {1'b1, hold});
                    else n_pass++;
                end
                bus0.PIX_READY = 1'b1;
            end
        end
        n_checks++; if (n >= 150) $display("FAIL stall_done_timeout: waited %0d cycles, required < 150", n); else n_pass++;
        n_checks++; if (stalled !== 1'b1) $display("FAIL stall_reached: got %b, required 1", stalled); else n_pass++;
        n_checks++; if (hold !== {16'h5A5A, 9'd2, 8'd0}) $display("FAIL stall_pixel: got %h, required %h", hold, {16'h5A5A, 9'd2, 8'd0}); else n_pass++;
        @(posedge CLK); #2;
        n_checks++; if (got0_q.size() !== exp_q.size()) $display("FAIL stall_count: got %0d, required %0d", got0_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got0_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got0_q[i] !== exp_q[i]) $display("FAIL stall_pix[%0d]: got %h, required %h", i, got0_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_clip();
        int d, n;
        got0_q.delete();
        d = done0;
        send_tri(0, mk_tri(16'd25600, 0, 16'd25600, 256, 16'd25856, 0, 16'h7777));
        wait_done(0, d, 20, n);
        n_checks++; if (n > 3) $display("FAIL clip_done_latency: got %0d cycles, required <= 3", n); else n_pass++;
        @(posedge CLK); #2;
        n_checks++; if (got0_q.size() !== 0) $display("FAIL clip_count: got %0d, required 0", got0_q.size()); else n_pass++;
        n_checks++; if (done0 - d !== 1) $display("FAIL clip_done_pulses: got %0d, required 1", done0 - d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d;
        got0_q.delete();
        d = done0;
        send_tri(0, mk_tri(0, 0, 0, 256, 256, 0, 16'hC0DE));
        repeat (8) @(posedge CLK);
        #1;
        n_checks++; if (bus0.BUSY !== 1'b1) $display("FAIL midrst_busy_before: got %b, required 1", bus0.BUSY); else n_pass++;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({bus0.TRI_READY, bus0.PIX_VALID, bus0.DONE, bus0.BUSY, bus0.PIX_INSIDE} !== 5'b10000)
            $display("FAIL midrst_flags: got %b, required 10000",
                     {bus0.TRI_READY, bus0.PIX_VALID, bus0.DONE, bus0.BUSY, bus0.PIX_INSIDE});
        else n_pass++;
        n_checks++;
        if ({bus0.PIX_X, bus0.PIX_Y, bus0.PIX_COLOR} !== '0)
            $display("FAIL midrst_pix: got %h, required 0", {bus0.PIX_X, bus0.PIX_Y, bus0.PIX_COLOR});
        else n_pass++;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        n_checks++; if (done0 !== d) $display("FAIL midrst_no_done: got %0d pulses, required 0", done0 - d); else n_pass++;
        test_inside_only();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.TRI_VALID = 1'b0; bus0.TRI_IN = '0; bus0.PIX_READY = 1'b1;
        bus1.TRI_VALID = 1'b0; bus1.TRI_IN = '0; bus1.PIX_READY = 1'b1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        RST = 1'b0;
        @(posedge CLK);
        #1;
        test_inside_only();
        test_emit_all();
        test_winding();
        test_stall();
        test_clip();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
